// File: rtl/bg_rle_writer_pkg.sv
// bg_pkg: background geometry, RLE byte layout and writer states shared with the display path
package bg_pkg;
  localparam int BG_WIDTH = 400;
  localparam int BG_HEIGHT = 300;
  localparam int BG_PIXELS = BG_WIDTH * BG_HEIGHT;
  localparam int ADDR_W = 17;
  localparam int RUN_W = 6;
  localparam int RLE_LEN_HI = 7;
  localparam int RLE_LEN_LO = 3;
  localparam int RLE_IDX_HI = 2;
  localparam int RLE_IDX_LO = 0;
  typedef enum logic [1:0] {IDLE, ACCEPT, RUN, DONE} bg_wr_state_t;
  function automatic logic [ADDR_W-1:0] bg_addr(input logic [8:0] x, input logic [8:0] y);
    return ADDR_W'(x) + ADDR_W'(y) * ADDR_W'(BG_WIDTH);
  endfunction
endpackage

// File: rtl/bg_rle_writer_if.sv
// bg_rle_writer_if: RLE byte stream in, background memory write port out
interface bg_rle_writer_if import bg_pkg::*; #(parameter int AW = ADDR_W);
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic wr_en;
  logic [AW-1:0] wr_address;
  logic [3:0] wr_data;
  modport master(output in_data, in_valid, input in_ready, wr_en, wr_address, wr_data);
  modport slave(input in_data, in_valid, output in_ready, wr_en, wr_address, wr_data);
endinterface

// File: rtl/bg_rle_writer.sv
// bg_rle_writer: expands an RLE byte stream into row-major background index memory writes
module bg_rle_writer import bg_pkg::*; #(
  parameter int BG_PIXELS = bg_pkg::BG_PIXELS,
  parameter int ADDR_W = bg_pkg::ADDR_W
) (
  input logic Clk,
  input logic Reset,
  input logic start,
  bg_rle_writer_if.slave bus,
  output logic busy,
  output logic done,
  output logic overrun
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BG_PIXELS - 1);
  bg_wr_state_t state_q, state_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [2:0] idx_q, idx_d;
  logic overrun_q, overrun_d;
  logic restart, accept, writing, last_pix;
  assign restart = (state_q == IDLE || state_q == DONE) && start;
  assign accept = state_q == ACCEPT && bus.in_valid;
  assign writing = state_q == RUN;
  assign last_pix = pix_cnt_q == LAST;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pix_cnt_q <= '0;
      run_cnt_q <= '0;
      idx_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_cnt_q <= pix_cnt_d;
      run_cnt_q <= run_cnt_d;
      idx_q <= idx_d;
      overrun_q <= overrun_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start ? ACCEPT : state_q;
      ACCEPT: state_d = bus.in_valid ? RUN : ACCEPT;
      RUN: state_d = last_pix ? DONE : (run_cnt_q == RUN_W'(1) ? ACCEPT : RUN);
      default: state_d = IDLE;
    endcase
  end
  // the pixel counter holds at the last address so it can never wrap past the frame
  always_comb begin
    pix_cnt_d = pix_cnt_q;
    run_cnt_d = run_cnt_q;
    idx_d = idx_q;
    overrun_d = overrun_q;
    if (restart) begin
      pix_cnt_d = '0;
      run_cnt_d = '0;
      overrun_d = 1'b0;
    end
    if (accept) begin
      idx_d = bus.in_data[RLE_IDX_HI:RLE_IDX_LO];
      run_cnt_d = RUN_W'(bus.in_data[RLE_LEN_HI:RLE_LEN_LO]) + RUN_W'(1);
    end
    if (writing) begin
      pix_cnt_d = last_pix ? pix_cnt_q : pix_cnt_q + ADDR_W'(1);
      run_cnt_d = run_cnt_q - RUN_W'(1);
      overrun_d = (last_pix && run_cnt_q > RUN_W'(1)) ? 1'b1 : overrun_q;
    end
  end
  always_comb begin
    bus.in_ready = state_q == ACCEPT;
    bus.wr_en = writing;
    bus.wr_address = writing ? pix_cnt_q : '0;
    bus.wr_data = writing ? {1'b0, idx_q} : 4'h0;
    busy = state_q == ACCEPT || state_q == RUN;
    done = state_q == DONE;
    overrun = overrun_q;
  end
endmodule

// File: tb/tb_bg_rle_writer.sv
// tb_bg_rle_writer: directed checks of the RLE writer on a 400x4 frame so full-frame runs stay short
module tb_bg_rle_writer;
  localparam int PIX = 1600;
  localparam int LOG_N = 8192;
  logic Clk = 1'b0;
  logic Reset, start, busy, done, overrun;
  int passed = 0;
  int total = 0;
  int wr_total = 0;
  int log_addr [LOG_N];
  int log_data [LOG_N];
  bg_rle_writer_if #(.AW(17)) bus();
  bg_rle_writer #(.BG_PIXELS(PIX), .ADDR_W(17)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .bus(bus),
    .busy(busy), .done(done), .overrun(overrun)
  );
  always #5 Clk = ~Clk;
  always @(negedge Clk) begin
    if (bus.wr_en && wr_total < LOG_N) begin
      log_addr[wr_total] = int'(bus.wr_address);
      log_data[wr_total] = int'(bus.wr_data);
      wr_total++;
    end
  end
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic send(input logic [7:0] b);
    bus.in_data = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40 && !bus.in_ready; i++) tick();
    if (!bus.in_ready) chk("ready_timeout", {31'b0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask
  task automatic restart();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  function automatic int seg_bad(input int n0, input int cnt, input int a0, input int d);
    int bad = 0;
    for (int i = 0; i < cnt; i++)
      if (n0 + i >= LOG_N || log_addr[n0+i] != a0 + i || log_data[n0+i] != d) bad++;
    return bad;
  endfunction
  initial begin
    int n0, n1, lowc;
    Reset = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (2) tick();
    chk("rst_in_ready", {31'b0, bus.in_ready}, 0);
    chk("rst_wr_en", {31'b0, bus.wr_en}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_overrun", {31'b0, overrun}, 0);
    chk("rst_wr_address", 32'(bus.wr_address), 0);
    chk("rst_wr_data", 32'(bus.wr_data), 0);
    Reset = 1'b0;
    tick();
    chk("idle_in_ready", {31'b0, bus.in_ready}, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ready", {31'b0, bus.in_ready}, 1);
    chk("start_busy", {31'b0, busy}, 1);
    n0 = wr_total;
    send(8'hFA);
    lowc = 0;
    for (int i = 0; i < 32; i++) begin
      if (!bus.in_ready && bus.wr_en) lowc++;
      tick();
    end
    chk("fa_ready_low_cycles", lowc, 32);
    chk("fa_ready_back", {31'b0, bus.in_ready}, 1);
    chk("fa_write_count", wr_total - n0, 32);
    chk("fa_segment", seg_bad(n0, 32, 0, 2), 0);
    restart();
    n0 = wr_total;
    send(8'h01);
    tick();
    n1 = wr_total;
    repeat (5) tick();
    chk("gap_no_writes", wr_total - n1, 0);
    chk("gap_ready", {31'b0, bus.in_ready}, 1);
    send(8'h0B);
    repeat (2) tick();
    chk("gap_write_count", wr_total - n0, 3);
    chk("gap_first", seg_bad(n0, 1, 0, 1), 0);
    chk("gap_second", seg_bad(n0 + 1, 2, 1, 3), 0);
    restart();
    n0 = wr_total;
    send(8'h7D);
    repeat (2) tick();
    Reset = 1'b1;
    tick();
    chk("midrst_wr_en", {31'b0, bus.wr_en}, 0);
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_writes", wr_total - n0, 3);
    Reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n0 = wr_total;
    send(8'h00);
    tick();
    chk("midrst_restart_addr", seg_bad(n0, 1, 0, 0), 0);
    restart();
    n0 = wr_total;
    send(8'hFA);
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_start_busy", {31'b0, busy}, 1);
    chk("run_start_wr_en", {31'b0, bus.wr_en}, 1);
    send(8'h0A);
    repeat (2) tick();
    chk("run_start_count", wr_total - n0, 34);
    chk("run_start_seq_a", seg_bad(n0, 32, 0, 2), 0);
    chk("run_start_seq_b", seg_bad(n0 + 32, 2, 32, 2), 0);
    restart();
    n0 = wr_total;
    for (int i = 0; i < PIX / 32; i++) send(8'hFF);
    repeat (31) tick();
    chk("frame_last_addr", 32'(bus.wr_address), PIX - 1);
    chk("frame_done_early", {31'b0, done}, 0);
    tick();
    chk("frame_done", {31'b0, done}, 1);
    chk("frame_busy", {31'b0, busy}, 0);
    chk("frame_overrun", {31'b0, overrun}, 0);
    chk("frame_count", wr_total - n0, PIX);
    chk("frame_segment", seg_bad(n0, PIX, 0, 7), 0);
    n1 = wr_total;
    bus.in_data = 8'hFF;
    bus.in_valid = 1'b1;
    lowc = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.in_ready) lowc++;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("done_ready_high_cycles", lowc, 0);
    chk("done_no_writes", wr_total - n1, 0);
    restart();
    n0 = wr_total;
    for (int i = 0; i < PIX / 32 - 1; i++) send(8'hF8);
    send(8'h38);
    repeat (8) tick();
    n1 = wr_total;
    send(8'hF9);
    repeat (24) tick();
    chk("ovr_last_writes", wr_total - n1, 24);
    chk("ovr_segment", seg_bad(n1, 24, PIX - 24, 1), 0);
    chk("ovr_total", wr_total - n0, PIX);
    chk("ovr_overrun", {31'b0, overrun}, 1);
    chk("ovr_done", {31'b0, done}, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("redo_done", {31'b0, done}, 0);
    chk("redo_overrun", {31'b0, overrun}, 0);
    chk("redo_ready", {31'b0, bus.in_ready}, 1);
    n0 = wr_total;
    send(8'h02);
    tick();
    chk("redo_count", wr_total - n0, 1);
    chk("redo_first", seg_bad(n0, 1, 0, 2), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
